// File: rtl/alpharetz_wb_arbiter.sv
// Round-robin writeback arbiter for the single regfile write port, with a per-register busy scoreboard.
// Define ALPHARETZ_WB_FWD_EN to add the combinational forwarding outputs fwd_valid/fwd_addr/fwd_data.
module alpharetz_wb_arbiter #(
    parameter int NUM_WB_SRC     = 3,
    parameter int CPU_DATA_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CPU_REG_COUNT  = 32
) (
    input  logic                                 clk,
    input  logic                                 async_rst_n,
    input  logic                                 clk_en,
    input  logic                                 sys_en,
    input  logic [NUM_WB_SRC-1:0]                wb_valid,
    output logic [NUM_WB_SRC-1:0]                wb_ready,
    input  logic [NUM_WB_SRC*REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [NUM_WB_SRC*CPU_DATA_WIDTH-1:0] wb_data,
    input  logic                                 iss_en,
    input  logic [REG_ADDR_WIDTH-1:0]            iss_addr,
    output logic                                 iss_hazard,
    input  logic                                 flush,
    output logic [CPU_REG_COUNT-1:0]             busy_mask,
`ifdef ALPHARETZ_WB_FWD_EN
    output logic                                 fwd_valid,
    output logic [REG_ADDR_WIDTH-1:0]            fwd_addr,
    output logic [CPU_DATA_WIDTH-1:0]            fwd_data,
`endif
    output logic                                 rf_wr_en,
    output logic [REG_ADDR_WIDTH-1:0]            rf_wr_addr,
    output logic [CPU_DATA_WIDTH-1:0]            rf_wr_data
);

    localparam int IW = (NUM_WB_SRC > 1) ? $clog2(NUM_WB_SRC) : 1;

    logic                      adv;
    logic [IW-1:0]             last_grant;
    logic [IW-1:0]             win;
    logic [NUM_WB_SRC-1:0]     grant;
    logic                      xfer;
    logic                      wr_real;
    logic [REG_ADDR_WIDTH-1:0] win_addr;
    logic [CPU_DATA_WIDTH-1:0] win_data;
    logic [CPU_REG_COUNT-1:0]  busy;
    logic [CPU_REG_COUNT-1:0]  busy_nxt;

    assign adv = clk_en && sys_en;

    // Scan starts one past the last winner, so every requester is served within NUM_WB_SRC transfers.
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        win   = '0;
        xfer  = 1'b0;
        if (adv) begin
            for (int k = 0; k < NUM_WB_SRC; k++) begin
                idx = (int'(last_grant) + 1 + k) % NUM_WB_SRC;
                if (!xfer && wb_valid[idx]) begin
                    xfer       = 1'b1;
                    grant[idx] = 1'b1;
                    win        = IW'(idx);
                end
            end
        end
    end

    assign wb_ready = grant;
    assign win_addr = wb_addr[int'(win)*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign win_data = wb_data[int'(win)*CPU_DATA_WIDTH +: CPU_DATA_WIDTH];
    // r0 transfers complete the handshake but never reach the regfile.
    assign wr_real  = xfer && (win_addr != '0);

`ifdef ALPHARETZ_WB_FWD_EN
    assign fwd_valid = wr_real;
    assign fwd_addr  = win_addr;
    assign fwd_data  = win_data;
`endif

    // Ordering makes a same-edge issue win over both flush and writeback clear.
    always_comb begin
        busy_nxt = busy;
        if (flush)
            busy_nxt = '0;
        if (xfer)
            busy_nxt[win_addr] = 1'b0;
        if (iss_en && (iss_addr != '0))
            busy_nxt[iss_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    assign busy_mask  = busy;
    assign iss_hazard = (iss_addr != '0) && busy[iss_addr];

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            busy       <= '0;
            last_grant <= IW'(NUM_WB_SRC - 1);
        end else begin
            rf_wr_en <= wr_real;
            if (wr_real) begin
                rf_wr_addr <= win_addr;
                rf_wr_data <= win_data;
            end
            if (adv) begin
                busy <= busy_nxt;
                if (xfer)
                    last_grant <= win;
            end
        end
    end

endmodule

// File: tb/tb_alpharetz_wb_arbiter.sv
// Directed and randomized bench for alpharetz_wb_arbiter, checked against a queue-free rule model.
// Covers ALPHARETZ_WB_FWD_EN outputs when that macro is defined.
module tb_alpharetz_wb_arbiter;
    localparam int N = 3;
    localparam int D = 32;
    localparam int W = 5;
    localparam int R = 32;

    logic           clk = 1'b0;
    logic           async_rst_n;
    logic           clk_en;
    logic           sys_en;
    logic [N-1:0]   wb_valid;
    logic [N-1:0]   wb_ready;
    logic [N*W-1:0] wb_addr;
    logic [N*D-1:0] wb_data;
    logic           iss_en;
    logic [W-1:0]   iss_addr;
    logic           iss_hazard;
    logic           flush;
    logic [R-1:0]   busy_mask;
    logic           rf_wr_en;
    logic [W-1:0]   rf_wr_addr;
    logic [D-1:0]   rf_wr_data;
`ifdef ALPHARETZ_WB_FWD_EN
    logic           fwd_valid;
    logic [W-1:0]   fwd_addr;
    logic [D-1:0]   fwd_data;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: who last won, which registers are pending, what the regfile port shows.
    int           m_last;
    int           m_g;
    logic [R-1:0] m_busy;
    logic         m_en;
    logic [W-1:0] m_addr;
    logic [D-1:0] m_data;

    alpharetz_wb_arbiter dut (
        .clk        (clk),
        .async_rst_n(async_rst_n),
        .clk_en     (clk_en),
        .sys_en     (sys_en),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .iss_en     (iss_en),
        .iss_addr   (iss_addr),
        .iss_hazard (iss_hazard),
        .flush      (flush),
        .busy_mask  (busy_mask),
`ifdef ALPHARETZ_WB_FWD_EN
        .fwd_valid  (fwd_valid),
        .fwd_addr   (fwd_addr),
        .fwd_data   (fwd_data),
`endif
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic src(input int i, input logic v, input logic [W-1:0] a, input logic [D-1:0] d);
        wb_valid[i]      = v;
        wb_addr[i*W +: W] = a;
        wb_data[i*D +: D] = d;
    endtask

    task automatic model_reset();
        m_last = N - 1;
        m_g    = -1;
        m_busy = '0;
        m_en   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // Called at a negedge after inputs are set; checks one full cycle and returns at the next negedge.
    task automatic step();
        logic         adv;
        logic [N-1:0] er;
        logic [W-1:0] ga;
        logic [D-1:0] gd;
        logic [R-1:0] nb;
        int           j;
        #1;
        adv = clk_en && sys_en;
        m_g = -1;
        if (adv) begin
            for (int k = 0; k < N; k++) begin
                j = (m_last + 1 + k) % N;
                if (m_g < 0 && wb_valid[j]) m_g = j;
            end
        end
        er = '0;
        ga = '0;
        gd = '0;
        if (m_g >= 0) begin
            er[m_g] = 1'b1;
            ga = wb_addr[m_g*W +: W];
            gd = wb_data[m_g*D +: D];
        end
        chk("wb_ready", wb_ready, er);
        chk("iss_hazard", iss_hazard, (iss_addr != 0) && m_busy[iss_addr]);
`ifdef ALPHARETZ_WB_FWD_EN
        chk("fwd_valid", fwd_valid, (m_g >= 0) && (ga != 0));
        if (m_g >= 0 && ga != 0) begin
            chk("fwd_addr", fwd_addr, ga);
            chk("fwd_data", fwd_data, gd);
        end
`endif
        @(posedge clk);
        if (adv) begin
            nb = flush ? '0 : m_busy;
            if (m_g >= 0) nb[ga] = 1'b0;
            if (iss_en && iss_addr != 0) nb[iss_addr] = 1'b1;
            m_busy = nb;
            if (m_g >= 0) m_last = m_g;
        end
        m_en = (m_g >= 0) && (ga != 0);
        if (m_en) begin
            m_addr = ga;
            m_data = gd;
        end
        #1;
        chk("rf_wr_en", rf_wr_en, m_en);
        if (m_en) begin
            chk("rf_wr_addr", rf_wr_addr, m_addr);
            chk("rf_wr_data", rf_wr_data, m_data);
        end
        chk("busy_mask", busy_mask, m_busy);
        @(negedge clk);
    endtask

    initial begin
        logic [R-1:0] exp_mask;
        async_rst_n = 1'b0;
        clk_en      = 1'b1;
        sys_en      = 1'b1;
        wb_valid    = '0;
        wb_addr     = '0;
        wb_data     = '0;
        iss_en      = 1'b0;
        iss_addr    = '0;
        flush       = 1'b0;
        model_reset();
        #12;
        chk("rst_wr_en", rf_wr_en, 0);
        chk("rst_wr_addr", rf_wr_addr, 0);
        chk("rst_wr_data", rf_wr_data, 0);
        chk("rst_busy", busy_mask, 0);
        @(negedge clk);
        async_rst_n = 1'b1;

        // Reset dropped while a write is on the port and source 1 is still requesting.
        iss_en = 1'b1;
        iss_addr = 5'd3;
        src(1, 1'b1, 5'd6, 32'h66);
        step();
        chk("pre_rst_busy3", busy_mask[3], 1);
        chk("pre_rst_wr_en", rf_wr_en, 1);
        iss_en = 1'b0;
        src(1, 1'b1, 5'd6, 32'h67);
        async_rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", rf_wr_en, 0);
        chk("mid_rst_busy", busy_mask, 0);
        model_reset();
        @(negedge clk);
        async_rst_n = 1'b1;

        // All three sources requesting: 0,1,2,0,1,2 with a write every cycle.
        src(0, 1'b1, 5'd1, 32'h100);
        src(1, 1'b1, 5'd2, 32'h200);
        src(2, 1'b1, 5'd3, 32'h300);
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("rr_order", wb_ready, 3'b001 << (c % 3));
            step();
            chk("rr_wr_en", rf_wr_en, 1);
            chk("rr_wr_addr", rf_wr_addr, (c % 3) + 1);
        end
        wb_valid = '0;

        // Issue r5, then source 2 writes it back.
        iss_en = 1'b1;
        iss_addr = 5'd5;
        step();
        chk("busy5_set", busy_mask[5], 1);
        iss_en = 1'b0;
        src(2, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        chk("haz5_pending", iss_hazard, 1);
        step();
        chk("busy5_clr", busy_mask[5], 0);
        chk("wb5_addr", rf_wr_addr, 5);
        chk("wb5_data", rf_wr_data, 32'hDEADBEEF);
        wb_valid = '0;
        #1;
        chk("haz5_clear", iss_hazard, 0);
        step();
        chk("hold_wr_en", rf_wr_en, 0);
        chk("hold_wr_addr", rf_wr_addr, 5);
        chk("hold_wr_data", rf_wr_data, 32'hDEADBEEF);

        // Same-edge issue and writeback of r7: set wins.
        src(0, 1'b1, 5'd7, 32'h77);
        iss_en = 1'b1;
        iss_addr = 5'd7;
        step();
        chk("busy7_setwins", busy_mask[7], 1);
        wb_valid = '0;

        // Flush with issue of r9 leaves only r9.
        flush = 1'b1;
        iss_addr = 5'd9;
        step();
        exp_mask = '0;
        exp_mask[9] = 1'b1;
        chk("flush_iss9", busy_mask, exp_mask);
        flush = 1'b0;
        iss_en = 1'b0;

        // Source 1 wins, then enables drop: nothing moves and the pointer holds.
        src(1, 1'b1, 5'd8, 32'h88);
        step();
        src(0, 1'b1, 5'd11, 32'h11);
        src(1, 1'b1, 5'd12, 32'h12);
        src(2, 1'b1, 5'd13, 32'h13);
        iss_en = 1'b1;
        iss_addr = 5'd10;
        clk_en = 1'b0;
        #1;
        chk("clk_en_ready", wb_ready, 0);
        step();
        chk("clk_en_wr_en", rf_wr_en, 0);
        chk("clk_en_busy10", busy_mask[10], 0);
        clk_en = 1'b1;
        sys_en = 1'b0;
        step();
        chk("sys_en_wr_en", rf_wr_en, 0);
        sys_en = 1'b1;
        iss_en = 1'b0;
        #1;
        chk("ptr_held", wb_ready, 3'b100);
        step();
        chk("ptr_held_addr", rf_wr_addr, 13);
        wb_valid = '0;

        // r0 write completes the handshake but never reaches the regfile.
        src(0, 1'b1, 5'd0, 32'hABC);
        #1;
        chk("r0_ready", wb_ready, 3'b001);
        step();
        chk("r0_wr_en", rf_wr_en, 0);
        wb_valid = '0;

`ifdef ALPHARETZ_WB_FWD_EN
        src(1, 1'b1, 5'd4, 32'h12345678);
        #1;
        chk("fwd4_valid", fwd_valid, 1);
        chk("fwd4_addr", fwd_addr, 4);
        chk("fwd4_data", fwd_data, 32'h12345678);
        step();
        wb_valid = '0;
`endif

        // Random traffic; a source holds its request until it is accepted.
        m_g = -1;
        for (int c = 0; c < 400; c++) begin
            clk_en   = ($urandom_range(0, 9) != 0);
            sys_en   = ($urandom_range(0, 19) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            iss_en   = ($urandom_range(0, 1) == 1);
            iss_addr = W'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                if (!wb_valid[i] || m_g == i)
                    src(i, ($urandom_range(0, 2) != 0), W'($urandom_range(0, 7)), $urandom());
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
